// File: rtl/minmax_tracker_pkg.sv
// Shared definitions for the min/max tracker: data width, FSM state
// encoding and the debug view exported by the top level.
package minmax_tracker_pkg;

  localparam int DATA_W = 4;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Debug view: FSM state, raw comparator outputs {g,e,l} and the running
  // extremes of the frame in progress.
  typedef struct packed {
    logic [1:0]        state;
    logic [2:0]        cmp_max;
    logic [2:0]        cmp_min;
    logic [DATA_W-1:0] cur_max;
    logic [DATA_W-1:0] cur_min;
  } dbg_t;

endpackage

// File: rtl/minmax_tracker_if.sv
// Sample-in / result-out bus of the min/max tracker.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready. The producer holds valid and its payload stable
// until that edge; ready may change freely and never depends on valid in
// the same cycle. The input channel carries in_data/in_last, the output
// channel carries out_max/out_min/out_count/out_sat.
//
// slave  : the tracker's view (consumes samples, produces results).
// master : the environment's view (sample source plus result sink).
interface minmax_tracker_if #(
  parameter int COUNT_W = 8
);
  import minmax_tracker_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_min;
  logic [COUNT_W-1:0] out_count;
  logic              out_sat;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_count, out_sat
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_count, out_sat
  );

endinterface

// File: rtl/minmax_tracker_magcom4bit.sv
// 4-bit unsigned magnitude comparator: exactly one of e/g/l is high,
// g meaning a > b and l meaning a < b.
module magcom4bit
  import minmax_tracker_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              e,
  output logic              g,
  output logic              l
);

  // Pure combinational compare of two unsigned operands
  always_comb begin
    e = (a == b);
    g = (a > b);
    l = (a < b);
  end

endmodule

// File: rtl/minmax_tracker.sv
// Per-frame min/max/count tracker. Samples arrive framed by in_last; the
// running extremes are maintained through two magnitude comparators and a
// single registered result is offered per frame, held until accepted.
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  minmax_tracker_if.slave        bus,
  output dbg_t                   dbg
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [1:0]         state;
  logic [DATA_W-1:0]  cur_max;
  logic [DATA_W-1:0]  cur_min;
  logic [COUNT_W-1:0] cur_cnt;
  logic               cur_sat;

  logic [DATA_W-1:0]  nxt_max;
  logic [DATA_W-1:0]  nxt_min;
  logic [COUNT_W-1:0] nxt_cnt;
  logic               nxt_sat;

  logic a_e, a_g, a_l;
  logic b_e, b_g, b_l;
  logic accept;

  // Comparator A: incoming sample against the running maximum
  magcom4bit u_cmp_max (
    .a (bus.in_data),
    .b (cur_max),
    .e (a_e),
    .g (a_g),
    .l (a_l)
  );

  // Comparator B: incoming sample against the running minimum
  magcom4bit u_cmp_min (
    .a (bus.in_data),
    .b (cur_min),
    .e (b_e),
    .g (b_g),
    .l (b_l)
  );

  // Ready is a pure state decode, held low while reset is asserted
  assign bus.in_ready = rst_n && (state != ST_HOLD);
  assign accept       = bus.in_valid && bus.in_ready;

  // Post-update frame statistics, assuming the current sample is accepted
  always_comb begin
    nxt_max = cur_max;
    nxt_min = cur_min;
    nxt_cnt = cur_cnt;
    nxt_sat = cur_sat;
    if (state == ST_IDLE) begin
      // First sample of a frame seeds both extremes
      nxt_max = bus.in_data;
      nxt_min = bus.in_data;
      nxt_cnt = CNT_ONE;
      nxt_sat = 1'b0;
    end else begin
      if (a_g) nxt_max = bus.in_data;
      if (b_l) nxt_min = bus.in_data;
      if (cur_cnt == CNT_MAX) begin
        nxt_sat = 1'b1;
      end else begin
        nxt_cnt = cur_cnt + CNT_ONE;
      end
    end
  end

  // FSM, running statistics and the registered per-frame result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cur_max       <= '0;
      cur_min       <= '0;
      cur_cnt       <= '0;
      cur_sat       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_max   <= '0;
      bus.out_min   <= '0;
      bus.out_count <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            cur_max <= nxt_max;
            cur_min <= nxt_min;
            cur_cnt <= nxt_cnt;
            cur_sat <= nxt_sat;
            if (bus.in_last) begin
              // Frame end: the last sample is already folded into nxt_*
              bus.out_max   <= nxt_max;
              bus.out_min   <= nxt_min;
              bus.out_count <= nxt_cnt;
              bus.out_sat   <= nxt_sat;
              bus.out_valid <= 1'b1;
              state         <= ST_HOLD;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Debug view for checkers
  always_comb begin
    dbg         = '0;
    dbg.state   = state;
    dbg.cmp_max = {a_g, a_e, a_l};
    dbg.cmp_min = {b_g, b_e, b_l};
    dbg.cur_max = cur_max;
    dbg.cur_min = cur_min;
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: a COUNT_W=8 instance for the main
// scenarios and a COUNT_W=2 instance for counter saturation.
module tb_minmax_tracker;
  import minmax_tracker_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dbg_t dbg1;
  dbg_t dbg2;

  minmax_tracker_if #(.COUNT_W(8)) bus1 ();
  minmax_tracker_if #(.COUNT_W(2)) bus2 ();

  minmax_tracker #(.COUNT_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .dbg   (dbg1)
  );

  minmax_tracker #(.COUNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2),
    .dbg   (dbg2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send1(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    bus1.in_last  = last;
    while (!bus1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send1_timeout: in_ready stayed %0b, expected 1", bus1.in_ready);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    bus2.in_valid = 1'b1;
    bus2.in_data  = d;
    bus2.in_last  = last;
    while (!bus2.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send2_timeout: in_ready stayed %0b, expected 1", bus2.in_ready);
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_max !== 4'd0 || bus1.out_min !== 4'd0 ||
        bus1.out_count !== 8'd0 || bus1.out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b max=%0d min=%0d cnt=%0d sat=%0b, expected all 0",
               bus1.out_valid, bus1.out_max, bus1.out_min, bus1.out_count, bus1.out_sat);
    end
    n_checks++;
    if (bus1.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready_low: got %0b, expected 0", bus1.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus1.in_ready !== 1'b1 || dbg1.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%0b state=%0d, expected ready=1 state=0",
               bus1.in_ready, dbg1.state);
    end
  endtask

  task automatic test_frame8();
    logic [3:0] vals [8];
    vals = '{4'd4, 4'd5, 4'd12, 4'd15, 4'd6, 4'd7, 4'd14, 4'd13};
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send1(vals[i], 1'b0);
      n_checks++;
      if (bus1.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL frame8_early_valid: sample %0d got out_valid=%0b, expected 0", i, bus1.out_valid);
      end
    end
    send1(vals[7], 1'b1);
    n_checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_max !== 4'd15 || bus1.out_min !== 4'd4 ||
        bus1.out_count !== 8'd8 || bus1.out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL frame8_result: got v=%0b max=%0d min=%0d cnt=%0d sat=%0b, expected 1/15/4/8/0",
               bus1.out_valid, bus1.out_max, bus1.out_min, bus1.out_count, bus1.out_sat);
    end
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL frame8_pulse: got v=%0b ready=%0b, expected v=0 ready=1",
               bus1.out_valid, bus1.in_ready);
    end
    n_checks++;
    if (bus1.out_max !== 4'd15 || bus1.out_min !== 4'd4 || bus1.out_count !== 8'd8) begin
      n_fail++;
      $display("FAIL frame8_retain: got max=%0d min=%0d cnt=%0d, expected 15/4/8",
               bus1.out_max, bus1.out_min, bus1.out_count);
    end
  endtask

  task automatic test_single();
    bus1.out_ready = 1'b0;
    send1(4'd9, 1'b1);
    n_checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_max !== 4'd9 || bus1.out_min !== 4'd9 ||
        bus1.out_count !== 8'd1) begin
      n_fail++;
      $display("FAIL single_result: got v=%0b max=%0d min=%0d cnt=%0d, expected 1/9/9/1",
               bus1.out_valid, bus1.out_max, bus1.out_min, bus1.out_count);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus1.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_hold_ready: cycle %0d got in_ready=%0b, expected 0", i, bus1.in_ready);
      end
      @(negedge clk);
    end
    bus1.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: got v=%0b ready=%0b, expected v=0 ready=1",
               bus1.out_valid, bus1.in_ready);
    end
  endtask

  task automatic test_equal();
    bus1.out_ready = 1'b1;
    send1(4'd7, 1'b0);
    for (int i = 1; i < 3; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = 4'd7;
      bus1.in_last  = (i == 2);
      #1;
      n_checks++;
      if (dbg1.state !== ST_ACCUM || dbg1.cmp_max !== 3'b010 || dbg1.cmp_min !== 3'b010) begin
        n_fail++;
        $display("FAIL equal_cmp_e: sample %0d got state=%0d cmp_max=%b cmp_min=%b, expected 1/010/010",
                 i, dbg1.state, dbg1.cmp_max, dbg1.cmp_min);
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus1.in_last  = 1'b0;
      n_checks++;
      if (dbg1.cur_max !== 4'd7 || dbg1.cur_min !== 4'd7) begin
        n_fail++;
        $display("FAIL equal_stored: sample %0d got cur_max=%0d cur_min=%0d, expected 7/7",
                 i, dbg1.cur_max, dbg1.cur_min);
      end
    end
    n_checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_max !== 4'd7 || bus1.out_min !== 4'd7 ||
        bus1.out_count !== 8'd3) begin
      n_fail++;
      $display("FAIL equal_result: got v=%0b max=%0d min=%0d cnt=%0d, expected 1/7/7/3",
               bus1.out_valid, bus1.out_max, bus1.out_min, bus1.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus1.out_ready = 1'b0;
    send1(4'd3, 1'b0);
    send1(4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_max !== 4'd3 || bus1.out_min !== 4'd1 ||
          bus1.out_count !== 8'd2 || bus1.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d got v=%0b max=%0d min=%0d cnt=%0d ready=%0b, expected 1/3/1/2/0",
                 i, bus1.out_valid, bus1.out_max, bus1.out_min, bus1.out_count, bus1.in_ready);
      end
      @(negedge clk);
    end
    bus1.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%0b ready=%0b, expected v=0 ready=1",
               bus1.out_valid, bus1.in_ready);
    end
  endtask

  task automatic test_saturation();
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send2(4'd2, 1'b0);
    send2(4'd2, 1'b1);
    n_checks++;
    if (bus2.out_valid !== 1'b1 || bus2.out_count !== 2'd3 || bus2.out_sat !== 1'b1 ||
        bus2.out_max !== 4'd2 || bus2.out_min !== 4'd2) begin
      n_fail++;
      $display("FAIL sat_result: got v=%0b cnt=%0d sat=%0b max=%0d min=%0d, expected 1/3/1/2/2",
               bus2.out_valid, bus2.out_count, bus2.out_sat, bus2.out_max, bus2.out_min);
    end
    @(negedge clk);
    send2(4'd8, 1'b1);
    n_checks++;
    if (bus2.out_valid !== 1'b1 || bus2.out_count !== 2'd1 || bus2.out_sat !== 1'b0 ||
        bus2.out_max !== 4'd8) begin
      n_fail++;
      $display("FAIL sat_clear: got v=%0b cnt=%0d sat=%0b max=%0d, expected 1/1/0/8",
               bus2.out_valid, bus2.out_count, bus2.out_sat, bus2.out_max);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus1.out_ready = 1'b1;
    send1(4'd10, 1'b0);
    send1(4'd11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_max !== 4'd0 || bus1.out_min !== 4'd0 ||
        bus1.out_count !== 8'd0 || bus1.out_sat !== 1'b0 || bus1.in_ready !== 1'b0 ||
        dbg1.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%0b max=%0d min=%0d cnt=%0d sat=%0b ready=%0b state=%0d, expected all 0",
               bus1.out_valid, bus1.out_max, bus1.out_min, bus1.out_count, bus1.out_sat,
               bus1.in_ready, dbg1.state);
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    send1(4'd5, 1'b1);
    n_checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_max !== 4'd5 || bus1.out_min !== 4'd5 ||
        bus1.out_count !== 8'd1) begin
      n_fail++;
      $display("FAIL midreset_newframe: got v=%0b max=%0d min=%0d cnt=%0d, expected 1/5/5/1",
               bus1.out_valid, bus1.out_max, bus1.out_min, bus1.out_count);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.in_last   = 1'b0;
    bus1.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.in_last   = 1'b0;
    bus2.out_ready = 1'b1;

    test_reset();
    test_frame8();
    test_single();
    test_equal();
    test_backpressure();
    test_saturation();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator. Accepts a framed stream of 4-bit samples over a valid/ready handshake.
- Uses the comparator's g/l/e outputs to track the running maximum and minimum. Counts the samples in each frame.
- Presents one registered result per frame on an output valid/ready handshake.
- Sits between the sample source and any consumer of per-frame statistics.

Parameters:
- COUNT_W, 8, width of the per-frame sample counter; the counter saturates at 2^COUNT_W-1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample present on in_data/in_last
- in_data  input  4  unsigned sample
- in_last  input  1  marks the final sample of the frame
- in_ready  output  1  block can accept a sample
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- out_max  output  4  largest sample in the frame
- out_min  output  4  smallest sample in the frame
- out_count  output  COUNT_W  number of samples in the frame (saturating)
- out_sat  output  1  the frame's count saturated

Behaviour:
- Reset is asynchronous on the falling edge of rst_n, which is active-low. Reset values:
  - state is IDLE
  - out_valid = 0, out_max = 0, out_min = 0, out_count = 0, out_sat = 0
  - internal cur_max, cur_min, cur_cnt and cur_sat are all 0
- in_ready is decoded from state: 1 in IDLE and ACCUM, 0 in HOLD. It is forced to 0 while rst_n is low.
- A sample is accepted on a rising edge when in_valid && in_ready.
- The FSM has three states: IDLE, ACCUM and HOLD.
- IDLE, on an accepted sample:
  - cur_max = cur_min = in_data, cur_cnt = 1, cur_sat = 0.
  - If in_last is 1, take the frame-end action (below).
  - Otherwise go to ACCUM.
- ACCUM, on an accepted sample:
  - Comparator A compares in_data against cur_max. If g=1, cur_max ← in_data.
  - Comparator B compares in_data against cur_min. If l=1, cur_min ← in_data.
  - On e=1 the stored value is unchanged.
  - Counter rule: if cur_cnt == 2^COUNT_W-1, hold cur_cnt and set cur_sat=1; otherwise cur_cnt+1.
  - If in_last is 1, take the frame-end action.
- Frame-end action, on the same edge that accepts the in_last sample:
  - Load out_max, out_min, out_count and out_sat with the post-update values, i.e. the last sample is included.
  - Set out_valid=1 and go to HOLD.
- Latency: out_valid rises one cycle after the last sample is accepted. A single-sample frame follows the same timing.
- HOLD:
  - in_ready=0.
  - All out_* stay stable while out_valid=1 && !out_ready.
  - On out_valid && out_ready: out_valid←0 and go to IDLE. The next sample can be accepted on the following edge; there is no same-cycle pass-through.
- After the handshake, out_max, out_min, out_count and out_sat keep their last values until the next frame end.
- in_valid=0 in ACCUM is a stall: no state change and no timeout.
- Reset mid-frame or in HOLD discards the partial frame and any pending result. All outputs return to their reset values.
- Arithmetic is unsigned 4-bit throughout. There is no sign interpretation.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and the DATA_W=4 constant.
- Sub-module: two instances of the existing magcom4bit (a, b → e, g, l):
  - Instance A: a=in_data, b=cur_max.
  - Instance B: a=in_data, b=cur_min.
- There is no other sub-module. The FSM, counter and output registers live in minmax_tracker.

Test Plan:
- Reset then an 8-sample frame 4, 5, 12, 15, 6, 7, 14, 13 (last on 13), out_ready=1:
  - out_valid pulses for 1 cycle, exactly 1 cycle after 13 is accepted.
  - out_max=15, out_min=4, out_count=8, out_sat=0.
- Single-sample frame 9 with last=1:
  - out_max=9, out_min=9, out_count=1.
  - in_ready=0 until the result is accepted.
- Equal-value frame 7, 7, 7:
  - Comparator e is asserted on every sample and the stored values never change.
  - out_max=7, out_min=7, out_count=3.
- Backpressure:
  - Frame 3, 1 with out_ready=0 for 5 cycles.
  - out_valid stays 1, outputs stay stable at max=3, min=1, count=2, and in_ready=0 throughout.
  - Raise out_ready: out_valid falls on the next edge and in_ready returns to 1.
- Saturation with COUNT_W=2:
  - Frame of 6 samples 2, 2, 2, 2, 2, 2.
  - out_count=3, out_sat=1. The next frame of 1 sample gives out_sat=0.
- Reset mid-frame:
  - After samples 10, 11, pulse rst_n low asynchronously, between clock edges.
  - All outputs go to 0 immediately. A new frame 5 with last=1 then gives max=5, min=5, count=1.
